// File: rtl/adc_mcp3201_pkg.sv
// Shared definitions for the MCP3201 conversion scheduler: FSM encoding,
// result width and default timing constants.
package adc_mcp3201_pkg;

  localparam int DATA_W                 = 12;
  localparam int DEFAULT_LATCH_CYCLES   = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 2048;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LATCH      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    CAPTURE    = 3'd4
  } sched_state_e;

endpackage

// File: rtl/adc_mcp3201_sample_sched_tick.sv
// Sample-rate tick generator: counts 0..period-1 while enabled and flags the
// terminal count. The period is re-sampled only at a wrap (or while disabled),
// so a mid-count change never shortens or stretches the running period.
module adc_sample_tick #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_eff;

  // Periods of 0 or 1 cannot produce a distinct terminal count, so clamp to 2.
  always_comb begin
    period_eff = period;
    if (period < PERIOD_W'(2)) begin
      period_eff = PERIOD_W'(2);
    end
  end

  assign tick = enable && (count == (period_q - PERIOD_W'(1)));

  // Free-running period counter; held at zero and reloaded while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      period_q <= period_eff;
    end else if (!enable) begin
      count    <= '0;
      period_q <= period_eff;
    end else if (tick) begin
      count    <= '0;
      period_q <= period_eff;
    end else begin
      count    <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/adc_mcp3201_sample_sched.sv
// Periodic conversion scheduler for the MCP3201 reader: issues the start pulse,
// follows cs_adc through the conversion, captures the result and offers it on a
// valid/ready handshake with sticky overrun/timeout flags.
// Optional macro ADC_SCHED_DAC_LATCH_EN adds a one-clock latch_dac strobe that
// fires in the cycle sample_valid is (re)loaded by a successful capture.
module adc_mcp3201_sample_sched
  import adc_mcp3201_pkg::*;
#(
  parameter int PERIOD_W       = 16,
  parameter int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int DATA_W         = adc_mcp3201_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                adc_latch,
  input  logic                adc_cs,
  input  logic [DATA_W-1:0]   adc_value,
  output logic [DATA_W-1:0]   sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                timeout,
  input  logic                clear_flags,
  output logic                busy
`ifdef ADC_SCHED_DAC_LATCH_EN
  ,
  output logic                latch_dac
`endif
);

  localparam int LATCH_W = $clog2(LATCH_CYCLES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e        state;
  sched_state_e        state_next;
  logic                tick;
  logic [LATCH_W-1:0]  latch_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                to_last;
  logic                abort;
  logic                capture;
  logic                consume;

  adc_sample_tick #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  assign to_last   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign capture   = (state == CAPTURE);
  assign consume   = sample_valid && sample_ready;
  assign adc_latch = (state == LATCH);
  assign busy      = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a successful cs rise on the last allowed cycle beats the abort.
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (latch_cnt == LATCH_W'(LATCH_CYCLES - 1)) begin
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (to_last) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (!adc_cs) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (adc_cs) begin
          state_next = CAPTURE;
        end else if (to_last) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch-width and conversion-timeout counters, each cleared outside its window.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      latch_cnt <= (state == LATCH) ? latch_cnt + LATCH_W'(1) : '0;
      to_cnt    <= ((state == WAIT_START) || (state == WAIT_DONE)) ? to_cnt + TO_W'(1) : '0;
    end
  end

  // Result register, handshake and sticky flags; set events win over clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (capture) begin
        sample       <= adc_value;
        sample_valid <= 1'b1;
      end else if (consume) begin
        sample_valid <= 1'b0;
      end

      if (capture && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end

      if (abort) begin
        timeout <= 1'b1;
      end else if (clear_flags) begin
        timeout <= 1'b0;
      end
    end
  end

`ifdef ADC_SCHED_DAC_LATCH_EN
  // DAC strobe aligned with the cycle the freshly captured sample appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_dac <= 1'b0;
    end else begin
      latch_dac <= capture;
    end
  end
`endif

endmodule

// File: tb/tb_adc_mcp3201_sample_sched.sv
// Directed/randomized bench for adc_mcp3201_sample_sched with a behavioural
// MCP3201 reader model. Expected timing comes from the scheduling rules:
// latch one clock after a tick, ticks every period clocks, valid two clocks
// after cs rises, ticks outside idle dropped.
module tb_adc_mcp3201_sample_sched;

  localparam int LATCH_LEN = 32;
  localparam int TO_LEN    = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic        adc_latch;
  logic        adc_cs;
  logic [11:0] adc_value;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        timeout;
  logic        clear_flags;
  logic        busy;
`ifdef ADC_SCHED_DAC_LATCH_EN
  logic        latch_dac;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit reader_dead = 1'b0;
  bit reader_busy = 1'b0;
  int conv_min    = 40;
  int conv_max    = 120;
  int forced_q[$];
  int val_q[$];
  int rise_q[$];

  adc_mcp3201_sample_sched dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .adc_latch    (adc_latch),
    .adc_cs       (adc_cs),
    .adc_value    (adc_value),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .clear_flags  (clear_flags),
    .busy         (busy)
`ifdef ADC_SCHED_DAC_LATCH_EN
    ,
    .latch_dac    (latch_dac)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reader: after a start pulse ends, drop cs for a random time,
  // then present the result and raise cs. Records value and cs-rise cycle.
  initial begin : reader
    int v;
    adc_cs    = 1'b1;
    adc_value = '0;
    forever begin
      @(negedge clk);
      if (adc_latch === 1'b1 && !reader_dead) begin
        reader_busy = 1'b1;
        while (adc_latch === 1'b1) @(negedge clk);
        repeat ($urandom_range(3, 1)) @(negedge clk);
        adc_cs    = 1'b0;
        adc_value = 12'($urandom_range(4095, 0));
        repeat ($urandom_range(conv_max, conv_min)) @(negedge clk);
        v = (forced_q.size() != 0) ? forced_q.pop_front() : int'($urandom_range(4095, 0));
        adc_value = 12'(v);
        adc_cs    = 1'b1;
        val_q.push_back(v);
        rise_q.push_back(cyc);
        reader_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit rdy, input int per);
    reset        = rst;
    enable       = en;
    sample_ready = rdy;
    period       = 16'(per);
  endtask

  task automatic waitLatch(input string tag, input int budget, output int at);
    int n = 0;
    while (adc_latch !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (adc_latch !== 1'b1) checkOutput({tag, "_latch_wait"}, adc_latch, 1);
    at = cyc;
  endtask

  task automatic waitValid(input string tag, input int budget, output int at);
    int n = 0;
    while (sample_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sample_valid !== 1'b1) checkOutput({tag, "_valid_wait"}, sample_valid, 1);
    at = cyc;
  endtask

  task automatic waitConv(input string tag, input int budget);
    int n = 0;
    while (rise_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rise_q.size() == 0) checkOutput({tag, "_conv_wait"}, rise_q.size(), 1);
  endtask

  task automatic popConv(input string tag, output int v, output int r);
    if (val_q.size() == 0) begin
      checkOutput({tag, "_conv_missing"}, val_q.size(), 1);
      v = -1;
      r = -1000;
    end else begin
      v = val_q.pop_front();
      r = rise_q.pop_front();
    end
  endtask

  initial begin : main
    int t0, at, vat, v, r, n, L, ts, te, earliest, vr, lr, dac;
    bit pv, pl, pd;

    clear_flags = 1'b0;
    applyStimulus(1, 1, 1, 2000);
    repeat (3) @(negedge clk);
    checkOutput("rst_latch", adc_latch, 0);
    checkOutput("rst_sample", sample, 0);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
`ifdef ADC_SCHED_DAC_LATCH_EN
    checkOutput("rst_latch_dac", latch_dac, 0);
`endif

    // Basic conversion at period 2000
    $display("[TB] basic conversion");
    forced_q.push_back(12'h801);
    applyStimulus(0, 1, 1, 2000);
    t0 = cyc;
    waitLatch("basic", 2100, at);
    checkOutput("basic_latch_cycle", at - t0, 2000);
    n = 0;
    while (adc_latch === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("basic_latch_len", n, LATCH_LEN);
    waitValid("basic", 400, vat);
    popConv("basic", v, r);
    checkOutput("basic_sample", sample, 12'h801);
    checkOutput("basic_valid_lat", vat - r, 2);
`ifdef ADC_SCHED_DAC_LATCH_EN
    checkOutput("basic_dac_on", latch_dac, 1);
`endif
    @(negedge clk);
    checkOutput("basic_valid_pulse", sample_valid, 0);
    checkOutput("basic_overrun", overrun, 0);
`ifdef ADC_SCHED_DAC_LATCH_EN
    checkOutput("basic_dac_off", latch_dac, 0);
`endif

    // Consumer stalled across two conversions
    $display("[TB] consumer stalled");
    forced_q.push_back(12'h123);
    forced_q.push_back(12'h456);
    applyStimulus(0, 1, 0, 2000);
    waitValid("stall1", 2500, vat);
    popConv("stall1", v, r);
    checkOutput("stall_first", sample, 12'h123);
    waitConv("stall2", 2500);
    checkOutput("stall_hold", sample, 12'h123);
    repeat (3) @(negedge clk);
    popConv("stall2", v, r);
    checkOutput("stall_overrun", overrun, 1);
    checkOutput("stall_sample", sample, 12'h456);
    checkOutput("stall_valid", sample_valid, 1);
    applyStimulus(0, 1, 1, 2000);
    @(negedge clk);
    applyStimulus(0, 1, 0, 2000);
    checkOutput("stall_consumed", sample_valid, 0);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    checkOutput("stall_overrun_clr", overrun, 0);

    // Dead ADC: cs never falls
    $display("[TB] dead adc");
    reader_dead = 1'b1;
    waitLatch("dead", 2500, at);
    n = 0;
    while (adc_latch === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    L   = cyc;
    dac = 0;
    for (int i = 1; i < TO_LEN; i++) begin
      @(negedge clk);
`ifdef ADC_SCHED_DAC_LATCH_EN
      if (latch_dac === 1'b1) dac++;
`endif
    end
    checkOutput("dead_pre_timeout", timeout, 0);
    checkOutput("dead_pre_busy", busy, 1);
    @(negedge clk);
    checkOutput("dead_cycle", cyc - L, TO_LEN);
    checkOutput("dead_timeout", timeout, 1);
    checkOutput("dead_idle", busy, 0);
    checkOutput("dead_valid", sample_valid, 0);
    checkOutput("dead_sample", sample, 12'h456);
`ifdef ADC_SCHED_DAC_LATCH_EN
    if (latch_dac === 1'b1) dac++;
    checkOutput("dead_dac_pulses", dac, 0);
`endif
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    checkOutput("dead_timeout_clr", timeout, 0);
    reader_dead = 1'b0;

    // Short period: ticks during conversions are dropped
    $display("[TB] short period");
    conv_min = 150;
    conv_max = 260;
    applyStimulus(0, 0, 1, 100);
    @(negedge clk);
    applyStimulus(0, 1, 1, 100);
    ts       = cyc;
    earliest = ts;
    for (int k = 0; k < 4; k++) begin
      waitLatch("short", 700, at);
      te = ts + 99;
      while (te < earliest) te += 100;
      checkOutput($sformatf("short_latch%0d", k), at - ts, te + 1 - ts);
      waitValid("short", 700, vat);
      popConv("short", v, r);
      checkOutput($sformatf("short_sample%0d", k), sample, v);
      checkOutput($sformatf("short_lat%0d", k), vat - r, 2);
      earliest = r + 2;
    end
    checkOutput("short_overrun", overrun, 0);

    // Reset during WAIT_DONE
    $display("[TB] reset mid-conversion");
    waitLatch("rstconv", 300, at);
    n = 0;
    while (adc_cs !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    applyStimulus(1, 0, 1, 100);
    @(negedge clk);
    checkOutput("rstconv_latch", adc_latch, 0);
    checkOutput("rstconv_sample", sample, 0);
    checkOutput("rstconv_valid", sample_valid, 0);
    checkOutput("rstconv_busy", busy, 0);
    applyStimulus(0, 0, 1, 100);
    waitConv("rstconv", 400);
    repeat (5) @(negedge clk);
    checkOutput("rstconv_nocap_valid", sample_valid, 0);
    checkOutput("rstconv_nocap_sample", sample, 0);
    checkOutput("rstconv_nocap_busy", busy, 0);
    val_q.delete();
    rise_q.delete();

    // Enable dropped during LATCH
    $display("[TB] enable drop");
    applyStimulus(0, 1, 1, 100);
    waitLatch("endrop", 300, at);
    repeat (5) @(negedge clk);
    applyStimulus(0, 0, 1, 100);
    pv  = sample_valid;
    pl  = adc_latch;
    vr  = 0;
    lr  = 0;
    dac = 0;
    vat = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (sample_valid === 1'b1 && pv !== 1'b1) begin
        vr++;
        vat = cyc;
      end
      if (adc_latch === 1'b1 && pl !== 1'b1) lr++;
`ifdef ADC_SCHED_DAC_LATCH_EN
      if (latch_dac === 1'b1) begin
        dac++;
        checkOutput("endrop_dac_with_valid", sample_valid, 1);
      end
`endif
      pv = sample_valid;
      pl = adc_latch;
    end
    checkOutput("endrop_samples", vr, 1);
    checkOutput("endrop_latches", lr, 0);
    checkOutput("endrop_idle", busy, 0);
    popConv("endrop", v, r);
    checkOutput("endrop_sample", sample, v);
    checkOutput("endrop_lat", vat - r, 2);
`ifdef ADC_SCHED_DAC_LATCH_EN
    checkOutput("endrop_dac_pulses", dac, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
